// File: rtl/hms_timekeeper_ctrl_pkg.sv
// Shared types and constants for the time-of-day controller.
package hms_pkg;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned BLINK_W        = 3;
  localparam int unsigned MOD10          = 10;
  localparam int unsigned MOD6           = 6;
  localparam int unsigned HR_MAX_HI      = 2;
  localparam int unsigned HR_MAX_LO_AT_2 = 3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  localparam logic [BLINK_W-1:0] BLINK_RUN = 3'b000;
  localparam logic [BLINK_W-1:0] BLINK_HR  = 3'b100;
  localparam logic [BLINK_W-1:0] BLINK_MIN = 3'b010;
  localparam logic [BLINK_W-1:0] BLINK_SEC = 3'b001;

  function automatic logic [BLINK_W-1:0] blink_of(state_e st);
    case (st)
      SET_HR:  return BLINK_HR;
      SET_MIN: return BLINK_MIN;
      SET_SEC: return BLINK_SEC;
      default: return BLINK_RUN;
    endcase
  endfunction

  function automatic state_e next_state(state_e st);
    case (st)
      RUN:     return SET_HR;
      SET_HR:  return SET_MIN;
      SET_MIN: return SET_SEC;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/hms_timekeeper_ctrl_if.sv
// Button/tick inputs and display-side outputs of the timekeeper.
interface hms_timekeeper_ctrl_if;
  import hms_pkg::*;

  logic                 tick;
  logic                 mode_btn;
  logic                 inc_btn;
  logic [DIGIT_W-1:0]   sec_lo;
  logic [DIGIT_W-1:0]   sec_hi;
  logic [DIGIT_W-1:0]   min_lo;
  logic [DIGIT_W-1:0]   min_hi;
  logic [DIGIT_W-1:0]   hr_lo;
  logic [DIGIT_W-1:0]   hr_hi;
  logic [BLINK_W-1:0]   blink;
  logic                 day_pulse;

  modport master (
    output tick, mode_btn, inc_btn,
    input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, blink, day_pulse
  );

  modport slave (
    input  tick, mode_btn, inc_btn,
    output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, blink, day_pulse
  );
endinterface

// File: rtl/hms_timekeeper_ctrl_bcd_stage.sv
// Single BCD digit counter modulo N with terminal-count carry out.
module bcd_stage
  import hms_pkg::*;
#(
  parameter int unsigned N = MOD10
) (
  input  logic               CP,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] Q,
  output logic               TC
);

  localparam logic [DIGIT_W-1:0] TERM = DIGIT_W'(N - 1);

  assign TC = (Q == TERM) && en;

  // Clear wins over enable so a set-mode clear is never lost to a carry.
  always_ff @(posedge CP) begin
    if (rst) begin
      Q <= '0;
    end else if (clr) begin
      Q <= '0;
    end else if (en) begin
      Q <= (Q == TERM) ? '0 : Q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/hms_timekeeper_ctrl.sv
// Time-of-day controller: set-mode FSM, carry chain, 00-23 hour block, held tick.
module hms_timekeeper_ctrl
  import hms_pkg::*;
#(
  parameter bit TICK_HOLD = 1'b0
) (
  input logic                 CP,
  input logic                 rst,
  hms_timekeeper_ctrl_if.slave bus
);

  state_e               state_q;
  logic [BLINK_W-1:0]   blink_q;
  logic                 day_q;
  logic                 pend_q;

  logic [DIGIT_W-1:0]   sec_lo_q, sec_hi_q, min_lo_q, min_hi_q;
  logic [DIGIT_W-1:0]   hr_lo_q, hr_hi_q, hr_lo_d, hr_hi_d;
  logic                 sec_lo_tc, sec_hi_tc, min_lo_tc, min_hi_tc;

  logic run_c, adv_c, sec_clr_c, min_en_c, hr_adv_c, hr_wrap_c, rollover_c;

  assign run_c     = (state_q == RUN);
  assign adv_c     = run_c && (bus.tick || pend_q);
  assign sec_clr_c = (state_q == SET_SEC) && bus.inc_btn;
  assign min_en_c  = (run_c && sec_hi_tc) || ((state_q == SET_MIN) && bus.inc_btn);

  // Minute wrap only carries into the hour while running.
  assign hr_adv_c   = (run_c && min_hi_tc) || ((state_q == SET_HR) && bus.inc_btn);
  assign hr_wrap_c  = (hr_hi_q == DIGIT_W'(HR_MAX_HI)) && (hr_lo_q == DIGIT_W'(HR_MAX_LO_AT_2));
  assign rollover_c = run_c && min_hi_tc && hr_wrap_c;

  bcd_stage #(.N(MOD10)) u_sec_lo (
    .CP(CP), .rst(rst), .en(adv_c), .clr(sec_clr_c), .Q(sec_lo_q), .TC(sec_lo_tc)
  );

  bcd_stage #(.N(MOD6)) u_sec_hi (
    .CP(CP), .rst(rst), .en(sec_lo_tc), .clr(sec_clr_c), .Q(sec_hi_q), .TC(sec_hi_tc)
  );

  bcd_stage #(.N(MOD10)) u_min_lo (
    .CP(CP), .rst(rst), .en(min_en_c), .clr(1'b0), .Q(min_lo_q), .TC(min_lo_tc)
  );

  bcd_stage #(.N(MOD6)) u_min_hi (
    .CP(CP), .rst(rst), .en(min_lo_tc), .clr(1'b0), .Q(min_hi_q), .TC(min_hi_tc)
  );

  // Two-digit hour counter with the 23 -> 00 wrap.
  always_comb begin
    hr_lo_d = hr_lo_q;
    hr_hi_d = hr_hi_q;
    if (hr_adv_c) begin
      if (hr_wrap_c) begin
        hr_lo_d = '0;
        hr_hi_d = '0;
      end else if (hr_lo_q == DIGIT_W'(MOD10 - 1)) begin
        hr_lo_d = '0;
        hr_hi_d = hr_hi_q + DIGIT_W'(1);
      end else begin
        hr_lo_d = hr_lo_q + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge CP) begin
    if (rst) begin
      hr_lo_q <= '0;
      hr_hi_q <= '0;
    end else begin
      hr_lo_q <= hr_lo_d;
      hr_hi_q <= hr_hi_d;
    end
  end

  // Set-mode FSM with registered blink mask, day pulse and pending tick.
  // A pending tick that coincides with a fresh RUN tick stays pending one more cycle.
  always_ff @(posedge CP) begin
    if (rst) begin
      state_q <= RUN;
      blink_q <= BLINK_RUN;
      day_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      day_q <= rollover_c;
      if (run_c) begin
        pend_q <= pend_q && bus.tick;
      end else if (TICK_HOLD && bus.tick) begin
        pend_q <= 1'b1;
      end
      if (bus.mode_btn) begin
        state_q <= next_state(state_q);
        blink_q <= blink_of(next_state(state_q));
      end
    end
  end

  assign bus.sec_lo    = sec_lo_q;
  assign bus.sec_hi    = sec_hi_q;
  assign bus.min_lo    = min_lo_q;
  assign bus.min_hi    = min_hi_q;
  assign bus.hr_lo     = hr_lo_q;
  assign bus.hr_hi     = hr_hi_q;
  assign bus.blink     = blink_q;
  assign bus.day_pulse = day_q;

endmodule

// File: tb/tb_hms_timekeeper_ctrl.sv
// Bench for hms_timekeeper_ctrl: vector table, scripted corner cases, random vs. seconds-count model.
module tb_hms_timekeeper_ctrl;

  logic CP;
  logic rst;

  hms_timekeeper_ctrl_if if0 ();
  hms_timekeeper_ctrl_if if1 ();

  hms_timekeeper_ctrl #(.TICK_HOLD(1'b0)) dut0 (.CP(CP), .rst(rst), .bus(if0.slave));
  hms_timekeeper_ctrl #(.TICK_HOLD(1'b1)) dut1 (.CP(CP), .rst(rst), .bus(if1.slave));

  initial CP = 1'b0;
  always #5 CP = ~CP;

  logic [23:0] digs  [2];
  logic [2:0]  blnk  [2];
  logic        dayp  [2];

  assign digs[0] = {if0.hr_hi, if0.hr_lo, if0.min_hi, if0.min_lo, if0.sec_hi, if0.sec_lo};
  assign digs[1] = {if1.hr_hi, if1.hr_lo, if1.min_hi, if1.min_lo, if1.sec_hi, if1.sec_lo};
  assign blnk[0] = if0.blink;
  assign blnk[1] = if1.blink;
  assign dayp[0] = if0.day_pulse;
  assign dayp[1] = if1.day_pulse;

  int checks = 0;
  int errors = 0;
  string tag = "init";

  // Model: time as seconds since midnight, state as 0..3, one-deep pending flag.
  int m_t    [2];
  int m_st   [2];
  bit m_pend [2];
  bit m_day  [2];

  function automatic logic [23:0] bcd_of(int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [2:0] blink_exp(int st);
    case (st)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_update(input logic r, input logic t, input logic m, input logic i);
    int h, mi, s;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_t[k] = 0; m_st[k] = 0; m_pend[k] = 0; m_day[k] = 0;
      end else begin
        h  = m_t[k] / 3600;
        mi = (m_t[k] / 60) % 60;
        s  = m_t[k] % 60;
        m_day[k] = 0;
        case (m_st[k])
          0: begin
            if (t || m_pend[k]) begin
              m_t[k] = (m_t[k] + 1) % 86400;
              m_day[k] = (m_t[k] == 0);
            end
            m_pend[k] = m_pend[k] && t;
          end
          1: if (i) m_t[k] = ((h + 1) % 24) * 3600 + mi * 60 + s;
          2: if (i) m_t[k] = h * 3600 + ((mi + 1) % 60) * 60 + s;
          default: if (i) m_t[k] = h * 3600 + mi * 60;
        endcase
        if (m_st[k] != 0 && t && k == 1) m_pend[k] = 1;
        if (m) m_st[k] = (m_st[k] + 1) % 4;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (digs[k] !== bcd_of(m_t[k])) begin
        errors++;
        $display("FAIL %s dut%0d digits got %h want %h", tag, k, digs[k], bcd_of(m_t[k]));
      end
      checks++;
      if (blnk[k] !== blink_exp(m_st[k])) begin
        errors++;
        $display("FAIL %s dut%0d blink got %b want %b", tag, k, blnk[k], blink_exp(m_st[k]));
      end
      checks++;
      if (dayp[k] !== m_day[k]) begin
        errors++;
        $display("FAIL %s dut%0d day_pulse got %b want %b", tag, k, dayp[k], m_day[k]);
      end
    end
  endtask

  task automatic step(input logic r, input logic t, input logic m, input logic i);
    @(negedge CP);
    rst = r;
    if0.tick = t; if0.mode_btn = m; if0.inc_btn = i;
    if1.tick = t; if1.mode_btn = m; if1.inc_btn = i;
    @(posedge CP);
    model_update(r, t, m, i);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_dig(input int k, input logic [23:0] want, input string name);
    checks++;
    if (digs[k] !== want) begin
      errors++;
      $display("FAIL %s dut%0d digits got %h want %h", name, k, digs[k], want);
    end
  endtask

  task automatic expect_flag(input logic got, input logic want, input string name);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  typedef struct {
    logic        r, t, m, i;
    logic [23:0] dig;
    logic [2:0]  bl;
    logic        day;
  } vec_t;

  vec_t tbl [13];
  bit   saw_day;

  initial begin
    rst = 1'b1;
    if0.tick = 0; if0.mode_btn = 0; if0.inc_btn = 0;
    if1.tick = 0; if1.mode_btn = 0; if1.inc_btn = 0;
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_st[k] = 0; m_pend[k] = 0; m_day[k] = 0;
    end

    tbl[0]  = '{1, 0, 0, 0, 24'h000000, 3'b000, 0};
    tbl[1]  = '{0, 1, 0, 0, 24'h000001, 3'b000, 0};
    tbl[2]  = '{0, 0, 1, 0, 24'h000001, 3'b100, 0};
    tbl[3]  = '{0, 0, 0, 1, 24'h010001, 3'b100, 0};
    tbl[4]  = '{0, 0, 1, 1, 24'h020001, 3'b010, 0};
    tbl[5]  = '{0, 0, 0, 1, 24'h020101, 3'b010, 0};
    tbl[6]  = '{0, 1, 0, 0, 24'h020101, 3'b010, 0};
    tbl[7]  = '{0, 0, 1, 0, 24'h020101, 3'b001, 0};
    tbl[8]  = '{0, 0, 0, 1, 24'h020100, 3'b001, 0};
    tbl[9]  = '{0, 0, 1, 0, 24'h020100, 3'b000, 0};
    tbl[10] = '{0, 1, 0, 0, 24'h020101, 3'b000, 0};
    tbl[11] = '{0, 1, 1, 0, 24'h020102, 3'b100, 0};
    tbl[12] = '{1, 0, 0, 1, 24'h000000, 3'b000, 0};

    tag = "table";
    for (int v = 0; v < 13; v++) begin
      step(tbl[v].r, tbl[v].t, tbl[v].m, tbl[v].i);
      expect_dig(0, tbl[v].dig, $sformatf("table%0d", v));
      expect_flag(blnk[0], tbl[v].bl, $sformatf("table%0d blink", v));
      expect_flag(dayp[0], tbl[v].day, $sformatf("table%0d day", v));
    end

    // 61 ticks from reset.
    tag = "run61";
    step(1, 0, 0, 0);
    saw_day = 0;
    for (int c = 0; c < 61; c++) begin
      step(0, 1, 0, 0);
      if (dayp[0] || dayp[1]) saw_day = 1;
    end
    expect_dig(0, 24'h000101, "run61");
    expect_flag(saw_day, 1'b0, "run61 no day_pulse");

    // Preload 23:59:00 through set mode, then roll over midnight.
    tag = "rollover";
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); incs(23);
    step(0, 0, 1, 0); incs(59);
    step(0, 0, 1, 0); incs(1);
    step(0, 0, 1, 0);
    expect_dig(0, 24'h235900, "preload");
    ticks(59);
    expect_dig(0, 24'h235959, "pre rollover");
    expect_flag(dayp[0], 1'b0, "pre rollover day");
    ticks(1);
    expect_dig(0, 24'h000000, "rollover");
    expect_flag(dayp[0], 1'b1, "rollover day0");
    expect_flag(dayp[1], 1'b1, "rollover day1");
    idle(1);
    expect_flag(dayp[0], 1'b0, "day one cycle");

    // 25 hour presses wrap back to 01 without touching minutes/seconds.
    tag = "sethr25";
    step(1, 0, 0, 0);
    ticks(5);
    step(0, 0, 1, 0);
    incs(25);
    expect_dig(0, 24'h010005, "sethr25");
    expect_flag(blnk[0] == 3'b100, 1'b1, "sethr25 blink");
    step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);

    // Ticks during SET_MIN: dropped in dut0, one held in dut1.
    tag = "tickhold";
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    ticks(5);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    expect_dig(0, 24'h000000, "hold0 at run entry");
    expect_dig(1, 24'h000000, "hold1 at run entry");
    idle(1);
    expect_dig(0, 24'h000000, "hold0 first run");
    expect_dig(1, 24'h000001, "hold1 first run");
    idle(2);
    expect_dig(1, 24'h000001, "hold1 single");

    // Reset with inc_btn while editing 12:34:56.
    tag = "rstmid";
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); incs(12);
    step(0, 0, 1, 0); incs(34);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    ticks(56);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    expect_dig(0, 24'h123456, "rstmid preload");
    step(1, 0, 0, 1);
    expect_dig(0, 24'h000000, "rstmid digits");
    expect_flag(blnk[0] == 3'b000, 1'b1, "rstmid blink");

    // Tick and mode together in RUN at 00:00:09.
    tag = "tickmode";
    step(1, 0, 0, 0);
    ticks(9);
    step(0, 1, 1, 0);
    expect_dig(0, 24'h000010, "tickmode");
    expect_flag(blnk[0] == 3'b100, 1'b1, "tickmode set_hr");

    // Random traffic against the model.
    tag = "random";
    step(1, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hms_timekeeper_ctrl.md
# hms_timekeeper_ctrl

Time-of-day controller that sequences a chain of BCD digit counters (mod-10 / mod-6 stages plus a 00–23 hour stage) from a 1 Hz tick and provides a two-button set mode. It generates every stage enable and carry internally, so the digit counters never free-run, and presents six BCD digits plus a blink mask to the display driver. It sits between the tick prescaler / button debouncers and the 7-segment display mux.

## Interface
- `TICK_HOLD`, default 0: when 1, a tick arriving in a set state is held and applied on return to RUN; when 0, it is dropped.
- `CP` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: 1 Hz advance pulse, one CP cycle wide.
- `mode_btn` input 1: debounced single-cycle press; steps the set FSM.
- `inc_btn` input 1: debounced single-cycle press; edits the selected field.
- `sec_lo`, `sec_hi`, `min_lo`, `min_hi`, `hr_lo`, `hr_hi` output 4 each: BCD digits.
- `blink` output 3: field-select mask {hr, min, sec} for the display; bit high = field being edited.
- `day_pulse` output 1: one-cycle pulse on the 23:59:59 → 00:00:00 rollover.

## Operation
- FSM states: RUN, SET_HR, SET_MIN, SET_SEC.
  - `mode_btn` advances RUN → SET_HR → SET_MIN → SET_SEC → RUN.
  - All other inputs leave the state unchanged.
- RUN, on `tick`:
  - `sec_lo` counts mod 10. On its terminal count (9) with `tick`, `sec_hi` is enabled, mod 6.
  - `min_lo` is enabled when both second digits are terminal (59); `min_hi` counts mod 6.
  - The hour advances when mm:ss = 59:59.
    - `hr_lo` counts mod 10, except when `hr_hi` = 2, where 3 → 0 and `hr_hi` → 0.
    - `hr_lo` 9 → 0 increments `hr_hi`.
- Carry is the AND of the lower-stage terminal counts and `tick`. It propagates combinationally within one cycle, so all affected digits update on the same edge.
- Set states: the time is frozen; no stage is enabled by `tick`.
  - SET_HR: `inc_btn` increments the hour 00..23, wrapping 23 → 00, with no carry into or out of other fields.
  - SET_MIN: `inc_btn` increments the minute 00..59, wrapping 59 → 00; hours are unaffected.
  - SET_SEC: `inc_btn` clears the seconds to 00.
- `day_pulse` fires only on a RUN rollover, never on set-mode wraps.
- `blink`:
  - RUN = 000, SET_HR = 100, SET_MIN = 010, SET_SEC = 001.
  - Registered, so it changes on the same edge as the state.
- Simultaneous `mode_btn` and `inc_btn`: `inc_btn` acts on the current state, and the state advances on the same edge.
- `tick` in a set state:
  - With `TICK_HOLD` = 0, the tick is discarded.
  - With `TICK_HOLD` = 1, a one-deep pending flag is set. Additional ticks while pending are discarded.
  - The pending tick is applied on the first RUN cycle and the flag clears.
- Simultaneous `tick` and `mode_btn` in RUN: the tick is applied (time advances), and the state moves to SET_HR on the same edge.

## Timing
- Reset values (one `CP` edge with `rst` = 1):
  - all digits 0, state RUN, `blink` = 000, `day_pulse` = 0, pending flag 0.
- Reset overrides all inputs, including mid-set.
- Latency:
  - Digit outputs are registered; a `tick` at edge N appears at edge N (visible the cycle after `tick` is sampled high).
  - `day_pulse` is high in the same cycle that the digits read 00:00:00.
- Throughput: a `tick` on every cycle is legal; every tick advances the time by exactly 1 s.
- Digit values are always legal BCD within their range. No illegal state is reachable except through reset.

## Structure
- Shared package `hms_pkg`:
  - state enum (RUN, SET_HR, SET_MIN, SET_SEC);
  - constants MOD10 = 10, MOD6 = 6, HR_MAX_HI = 2, HR_MAX_LO_AT_2 = 3;
  - blink mask constants.
- Sub-module `bcd_stage`:
  - parameter N;
  - ports `CP`, `rst`, `en`, `clr`, `Q[3:0]`, `TC`;
  - `TC` = (Q == N−1) && en; `clr` has priority over `en`.
  - Instantiated for the four second/minute digits.
- Hours: implemented as a dedicated two-digit block inside the top, because of the 23 wrap.
- Top-level contents: FSM, carry/enable generation, set-mode increment muxing, pending-tick flag.

## Test plan
- Reset, then 61 ticks in RUN → 00:01:01, `day_pulse` never high.
- Preload via set mode to 23:59, clear seconds to 00, return to RUN, then tick 59 times.
  - At 23:59:59, one more tick → 00:00:00 with `day_pulse` high for exactly one cycle.
- SET_HR: 25 `inc_btn` presses from 00 → hours = 01.
  - Minutes and seconds are unchanged; `blink` = 100 throughout.
- `TICK_HOLD` = 0: 5 ticks in SET_MIN, then return to RUN → seconds unchanged.
- `TICK_HOLD` = 1, same stimulus → seconds advanced by exactly 1 on the first RUN cycle.
- Assert `rst` in SET_MIN with digits 12:34:56, together with `inc_btn`.
  - Next cycle: 00:00:00, state RUN, `blink` = 000.
- Same-cycle `tick` + `mode_btn` at 00:00:09 → 00:00:10, state SET_HR.
